// File: rtl/mem_access_stage_pkg.sv
// Shared encodings, request payload and lane/extension helpers for the MEM stage.
package mem_access_stage_pkg;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int unsigned CNT_BITS = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  offset;
    logic [1:0]  size;
    logic        uns;
    logic        store;
  } mem_req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      MEM_SIZE_HALF: return offset[0];
      MEM_SIZE_BYTE: return 1'b0;
      default:       return offset != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      MEM_SIZE_BYTE: return 4'b0001 << offset;
      MEM_SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:       return 4'b1111;
    endcase
  endfunction

  // Replicate the store data across lanes, then keep only the enabled bytes.
  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] size, input logic [1:0] offset);
    logic [31:0] lanes;
    logic [31:0] merged;
    logic [3:0]  be;
    case (size)
      MEM_SIZE_BYTE: lanes = {4{data[7:0]}};
      MEM_SIZE_HALF: lanes = {2{data[15:0]}};
      default:       lanes = data;
    endcase
    be = byte_enables(size, offset);
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? lanes[8*i +: 8] : old[8*i +: 8];
    end
    return merged;
  endfunction

  function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] offset);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    return shifted[7:0];
  endfunction

  function automatic logic [15:0] select_half(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

  function automatic logic [31:0] extend8(input logic [7:0] b, input logic uns);
    return uns ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] extend16(input logic [15:0] h, input logic uns);
    return uns ? {16'h0, h} : {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend_unit.sv
// Combinational byte/halfword lane select with sign or zero extension.
module load_extend_unit
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic        uns,
  output logic [31:0] byte_ext_c,
  output logic [31:0] half_ext_c
);

  assign byte_ext_c = extend8(select_byte(word, offset), uns);
  assign half_ext_c = extend16(select_half(word, offset[1]), uns);

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data memory with fixed access latency, byte-enabled stores and extended load views.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned ACCESS_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] AddressIn,
  input  logic [31:0] WriteDataIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        UnsignedIn,
  output logic [31:0] ReadDataMemOut,
  output logic [31:0] ExtendedByteOut,
  output logic [31:0] ExtendedHalfwordOut,
  output logic        Stall,
  output logic        MisalignOut
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(ACCESS_LATENCY - 1);

  logic [31:0] mem [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  mem_req_t             req_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [ADDR_BITS-1:0] idx_in;
  logic                 req_c, misalign_c, misalign_pulse_c, accept_c, commit_c;
  logic [31:0]          rd_word_c, byte_ext_c, half_ext_c;
  logic                 unused_addr;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign idx_in      = AddressIn[ADDR_BITS+1:2];
  assign unused_addr = ^AddressIn[31:ADDR_BITS+2];

  assign req_c      = MemReadIn | MemWriteIn;
  assign misalign_c = req_c & is_misaligned(MemSizeIn, AddressIn[1:0]);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    Stall            = 1'b0;
    accept_c         = 1'b0;
    commit_c         = 1'b0;
    misalign_pulse_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (misalign_c) begin
          misalign_pulse_c = 1'b1;
        end else if (req_c) begin
          Stall    = 1'b1;
          accept_c = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        Stall = 1'b1;
        if (cnt_q == '0) begin
          commit_c = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      // The same instruction is still presented here, so inputs are ignored.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      req_q <= '0;
      idx_q <= '0;
    end else if (accept_c) begin
      req_q <= '{data: WriteDataIn, offset: AddressIn[1:0], size: MemSizeIn,
                 uns: UnsignedIn, store: MemWriteIn};
      idx_q <= idx_in;
    end
  end

  // Stores take priority when read and write are both requested.
  always_ff @(posedge Clk) begin
    if (Reset && commit_c && req_q.store) begin
      mem[idx_q] <= merge_store(mem[idx_q], req_q.data, req_q.size, req_q.offset);
    end
  end

  assign rd_word_c = mem[idx_q];

  load_extend_unit u_load_extend (
    .word       (rd_word_c),
    .offset     (req_q.offset),
    .uns        (req_q.uns),
    .byte_ext_c (byte_ext_c),
    .half_ext_c (half_ext_c)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ReadDataMemOut      <= '0;
      ExtendedByteOut     <= '0;
      ExtendedHalfwordOut <= '0;
      MisalignOut         <= 1'b0;
    end else begin
      MisalignOut <= misalign_pulse_c;
      if (commit_c && !req_q.store) begin
        ReadDataMemOut      <= rd_word_c;
        ExtendedByteOut     <= byte_ext_c;
        ExtendedHalfwordOut <= half_ext_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] AddressIn;
  logic [31:0] WriteDataIn;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic [1:0]  MemSizeIn;
  logic        UnsignedIn;
  logic [31:0] ReadDataMemOut;
  logic [31:0] ExtendedByteOut;
  logic [31:0] ExtendedHalfwordOut;
  logic        Stall;
  logic        MisalignOut;

  int total = 0;
  int bad   = 0;
  int stalls;

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;

  mem_access_stage #(.ADDR_BITS(10), .ACCESS_LATENCY(2)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .AddressIn           (AddressIn),
    .WriteDataIn         (WriteDataIn),
    .MemReadIn           (MemReadIn),
    .MemWriteIn          (MemWriteIn),
    .MemSizeIn           (MemSizeIn),
    .UnsignedIn          (UnsignedIn),
    .ReadDataMemOut      (ReadDataMemOut),
    .ExtendedByteOut     (ExtendedByteOut),
    .ExtendedHalfwordOut (ExtendedHalfwordOut),
    .Stall               (Stall),
    .MisalignOut         (MisalignOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size, input logic uns);
    MemReadIn   = rd;
    MemWriteIn  = wr;
    AddressIn   = addr;
    WriteDataIn = data;
    MemSizeIn   = size;
    UnsignedIn  = uns;
  endtask

  // Issue one access and count Stall cycles; returns sitting in the DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] size, input logic uns,
                        output int n);
    @(negedge Clk);
    drive(rd, wr, addr, data, size, uns);
    #1;
    n = 0;
    while (Stall === 1'b1 && n < 40) begin
      n++;
      @(negedge Clk);
      #1;
    end
    MemReadIn  = 1'b0;
    MemWriteIn = 1'b0;
  endtask

  task automatic misaligned(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [1:0] size, input string tag);
    @(negedge Clk);
    drive(rd, wr, addr, 32'h5A5A5A5A, size, 1'b0);
    #1;
    check({tag, "_stall_req"}, 32'(Stall), 32'h0);
    @(posedge Clk);
    #1;
    check({tag, "_pulse"}, 32'(MisalignOut), 32'h1);
    check({tag, "_stall_pulse"}, 32'(Stall), 32'h0);
    @(negedge Clk);
    MemReadIn  = 1'b0;
    MemWriteIn = 1'b0;
    @(posedge Clk);
    #1;
    check({tag, "_pulse_end"}, 32'(MisalignOut), 32'h0);
  endtask

  initial begin
    Reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_rdata", ReadDataMemOut, 32'h0);
    check("rst_byte", ExtendedByteOut, 32'h0);
    check("rst_half", ExtendedHalfwordOut, 32'h0);
    check("rst_stall", 32'(Stall), 32'h0);
    check("rst_misalign", 32'(MisalignOut), 32'h0);
    Reset = 1'b1;

    // Word store then load
    access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, SZ_W, 1'b0, stalls);
    check("sw40_stalls", 32'(stalls), 32'd3);
    access(1'b1, 1'b0, 32'h40, 32'h0, SZ_W, 1'b0, stalls);
    check("lw40_stalls", 32'(stalls), 32'd3);
    check("lw40_word", ReadDataMemOut, 32'hDEADBEEF);
    check("lw40_byte", ExtendedByteOut, 32'hFFFFFFEF);
    check("lw40_half", ExtendedHalfwordOut, 32'hFFFFBEEF);

    // Byte lanes
    access(1'b0, 1'b1, 32'h80, 32'h11223344, SZ_W, 1'b0, stalls);
    access(1'b0, 1'b1, 32'h82, 32'h000000AA, SZ_B, 1'b0, stalls);
    check("sb82_stalls", 32'(stalls), 32'd3);
    access(1'b1, 1'b0, 32'h82, 32'h0, SZ_B, 1'b0, stalls);
    check("lb82_word", ReadDataMemOut, 32'h11AA3344);
    check("lb82_byte", ExtendedByteOut, 32'hFFFFFFAA);
    check("lb82_half", ExtendedHalfwordOut, 32'h000011AA);
    access(1'b1, 1'b0, 32'h82, 32'h0, SZ_B, 1'b1, stalls);
    check("lbu82_byte", ExtendedByteOut, 32'h000000AA);

    // Halfword lanes; upper store data bits must be dropped
    access(1'b0, 1'b1, 32'h84, 32'h55667788, SZ_W, 1'b0, stalls);
    access(1'b0, 1'b1, 32'h86, 32'hFFFF8001, SZ_H, 1'b0, stalls);
    access(1'b1, 1'b0, 32'h86, 32'h0, SZ_H, 1'b0, stalls);
    check("lh86_word", ReadDataMemOut, 32'h80017788);
    check("lh86_half", ExtendedHalfwordOut, 32'hFFFF8001);
    check("lh86_byte", ExtendedByteOut, 32'h00000001);
    access(1'b1, 1'b0, 32'h86, 32'h0, SZ_H, 1'b1, stalls);
    check("lhu86_half", ExtendedHalfwordOut, 32'h00008001);
    access(1'b1, 1'b0, 32'h84, 32'h0, SZ_H, 1'b1, stalls);
    check("lhu84_half", ExtendedHalfwordOut, 32'h00007788);
    check("lhu84_byte", ExtendedByteOut, 32'h00000088);

    // Misaligned accesses are rejected without stalling or touching state
    misaligned(1'b1, 1'b0, 32'h41, SZ_W, "lw41");
    misaligned(1'b1, 1'b0, 32'h43, SZ_H, "lh43");
    check("mis_hold_word", ReadDataMemOut, 32'h80017788);
    check("mis_hold_byte", ExtendedByteOut, 32'h00000088);
    check("mis_hold_half", ExtendedHalfwordOut, 32'h00007788);
    misaligned(1'b0, 1'b1, 32'h42, SZ_W, "sw42");
    access(1'b1, 1'b0, 32'h40, 32'h0, SZ_W, 1'b0, stalls);
    check("mis_no_write", ReadDataMemOut, 32'hDEADBEEF);

    // Reset on the cycle a store would commit
    access(1'b0, 1'b1, 32'h10, 32'h0BADC0DE, SZ_W, 1'b0, stalls);
    @(negedge Clk);
    drive(1'b0, 1'b1, 32'h10, 32'h12345678, SZ_W, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    MemWriteIn = 1'b0;
    #1;
    check("rstmid_busy_stall", 32'(Stall), 32'h1);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("rstmid_stall", 32'(Stall), 32'h0);
    check("rstmid_word", ReadDataMemOut, 32'h0);
    check("rstmid_byte", ExtendedByteOut, 32'h0);
    check("rstmid_half", ExtendedHalfwordOut, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    access(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, stalls);
    check("rstmid_lw_stalls", 32'(stalls), 32'd3);
    check("rstmid_lw_word", ReadDataMemOut, 32'h0BADC0DE);

    // Address wrap
    access(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, SZ_W, 1'b0, stalls);
    access(1'b1, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0, stalls);
    check("wrap_word", ReadDataMemOut, 32'hCAFEF00D);
    check("wrap_half", ExtendedHalfwordOut, 32'hFFFFF00D);

    // Read and write together: store commits, load outputs hold
    access(1'b1, 1'b1, 32'h20, 32'h600DD00D, SZ_W, 1'b0, stalls);
    check("both_stalls", 32'(stalls), 32'd3);
    check("both_hold_word", ReadDataMemOut, 32'hCAFEF00D);
    check("both_hold_byte", ExtendedByteOut, 32'h0000000D);
    access(1'b1, 1'b0, 32'h20, 32'h0, SZ_W, 1'b0, stalls);
    check("both_store_word", ReadDataMemOut, 32'h600DD00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data memory unit between the EX/MEM and MEM/WB pipeline registers.
- Performs word, halfword and byte loads and stores against an internal word-addressed data memory with configurable access latency.
- Produces the raw read word plus sign/zero-extended byte and halfword views that the MEM/WB register captures.
- Raises Stall while an access is in flight so the pipeline registers hold.

Parameters:
ADDR_BITS, 10, word-index width; memory depth = 2^ADDR_BITS words.
ACCESS_LATENCY, 2, BUSY cycles per access; legal range 1..15.

Ports:
Clk  in  1  clock; all state updates on posedge.
Reset  in  1  synchronous, active-low reset (Reset==0 resets on posedge Clk).
AddressIn  in  32  byte address from ALU result.
WriteDataIn  in  32  store data (rt value).
MemReadIn  in  1  load request.
MemWriteIn  in  1  store request.
MemSizeIn  in  2  00 word, 01 halfword, 10 byte, 11 treated as word.
UnsignedIn  in  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend.
ReadDataMemOut  out  32  aligned word read.
ExtendedByteOut  out  32  selected byte, extended.
ExtendedHalfwordOut  out  32  selected halfword, extended.
Stall  out  1  pipeline hold request.
MisalignOut  out  1  one-cycle pulse on a rejected misaligned access.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset value: IDLE. Counter reset value: 0.
- Output reset values: all data outputs 0, Stall 0, MisalignOut 0. Memory contents are not cleared by reset.
- req = MemReadIn | MemWriteIn. Word index = AddressIn[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- Misaligned access: halfword with AddressIn[0]=1, or word with AddressIn[1:0]!=0.
  - Evaluated in IDLE only.
  - Result: MisalignOut=1 for one cycle, FSM stays IDLE, no memory write, no Stall, read outputs unchanged.
- IDLE with aligned req:
  - Stall=1 combinationally in the same cycle.
  - At the edge, latch address, data, size, unsigned flag and op; load counter with ACCESS_LATENCY-1; go to BUSY.
- BUSY:
  - Stall=1.
  - If counter==0, go to DONE at the next edge; otherwise decrement.
  - Performing the access: stores write memory on the BUSY->DONE edge; loads register the outputs on the same edge.
- DONE:
  - Stall=0. Inputs are ignored because the same instruction is still presented.
  - Always returns to IDLE at the next edge.
- Stall cycles per access = ACCESS_LATENCY+1. Stall is low in the DONE cycle, when the outputs are valid.
- Stores: little-endian byte lanes. Byte lane = AddressIn[1:0]. Halfword lane = AddressIn[1].
  - Byte store writes only WriteDataIn[7:0] into the selected lane.
  - Halfword store writes only WriteDataIn[15:0] into the selected lane.
  - Word store writes all 32 bits.
  - Other lanes are preserved (read-modify-write with byte enables).
- Loads:
  - ReadDataMemOut = full word.
  - ExtendedByteOut = selected byte, extended per UnsignedIn.
  - ExtendedHalfwordOut = selected halfword, extended per UnsignedIn.
  - All three are registered regardless of MemSizeIn, and hold their value until the next completed load.
- MemReadIn and MemWriteIn both high: the store wins; load outputs are not updated.
- Reset low in any state: next edge goes to IDLE, Stall=0, outputs cleared, any pending store is discarded.

Decomposition:
- Shared package holds:
  - MEM_SIZE_WORD/HALF/BYTE encodings, also used by the control unit.
  - FSM state encoding (2-bit).
  - Lane-select and extension helper functions.
- One sub-module, load_extend_unit: purely combinational. Takes the word, byte offset and unsigned flag; returns the byte and halfword extensions. It is reused by writeback forwarding.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x40, then lw @0x40 with ACCESS_LATENCY=2 -> Stall high 3 cycles each; ReadDataMemOut=0xDEADBEEF in DONE.
- Byte lanes: sw 0x11223344 @0x80; sb 0xAA @0x82; lb @0x82 -> word 0x11AA3344, ExtendedByteOut=0xFFFFFFAA; lbu -> 0x000000AA.
- Halfword: sh 0x8001 @0x86, lh -> ExtendedHalfwordOut=0xFFFF8001; lhu -> 0x00008001; lane @0x84 unchanged.
- Misalign: lw @0x41 -> MisalignOut 1-cycle pulse, Stall never asserted, outputs unchanged; lh @0x43 same.
- Reset mid-access: start sw 0x12345678 @0x10, drop Reset in BUSY -> next edge IDLE, Stall 0, outputs 0; subsequent lw @0x10 returns the prior contents, not 0x12345678.
- Wrap and simultaneous: sw 0xCAFEF00D @0x1000 (ADDR_BITS=10), lw @0x0 -> 0xCAFEF00D; MemRead+MemWrite together -> store committed, read outputs hold their previous value.
